// File: rtl/tlb_assoc_pkg.sv
// Shared definitions for the fully-associative TLB: default geometry and walker states.
// Latency: none (types and constants only).
// Backpressure: none (no logic in this file).
package tlb_assoc_pkg;

    localparam int DEF_VA_W      = 32;
    localparam int DEF_PAGE_BITS = 12;
    localparam int DEF_ENTRIES   = 16;
    localparam int DEF_ASID_W    = 8;

    // IDLE accepts lookups/refills; FLUSH walks one entry per cycle.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } tlb_state_e;

endpackage

// File: rtl/tlb_assoc_match.sv
// Per-entry VPN/ASID compare with lowest-index priority encode (hit + index).
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the result with its own handshake.
module tlb_match
    import tlb_assoc_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int VPN_W   = DEF_VA_W - DEF_PAGE_BITS,
    parameter int ASID_W  = DEF_ASID_W,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]        ent_valid_i,
    input  logic [ENTRIES-1:0]        ent_global_i,
    input  logic [ENTRIES*VPN_W-1:0]  ent_vpn_i,
    input  logic [ENTRIES*ASID_W-1:0] ent_asid_i,
    input  logic [VPN_W-1:0]          key_vpn_i,
    input  logic [ASID_W-1:0]         key_asid_i,
    output logic                      hit_o,
    output logic [IDX_W-1:0]          idx_o
);

    logic [ENTRIES-1:0] match;

    // An entry matches on VPN when valid and either global or owned by the key ASID.
    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = ent_valid_i[i]
                     & (ent_vpn_i[i*VPN_W +: VPN_W] == key_vpn_i)
                     & (ent_global_i[i] | (ent_asid_i[i*ASID_W +: ASID_W] == key_asid_i));
        end
    end

    // Scan high to low so the lowest matching index is the last one written.
    always_comb begin
        hit_o = |match;
        idx_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_assoc.sv
// Fully-associative TLB: registered VPN->PFN lookup, refill with replacement, flush walker.
// Latency: lookup result one cycle after acceptance; flush takes exactly ENTRIES cycles.
// Backpressure: lookups and refills refused while flushing or while flush_i is raised.
module tlb_assoc
    import tlb_assoc_pkg::*;
#(
    parameter int VA_W      = DEF_VA_W,
    parameter int PAGE_BITS = DEF_PAGE_BITS,
    parameter int ENTRIES   = DEF_ENTRIES,
    parameter int ASID_W    = DEF_ASID_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lk_valid_i,
    output logic                      lk_ready_o,
    input  logic [VA_W-1:0]           lk_vaddr_i,
    input  logic [ASID_W-1:0]         lk_asid_i,
    output logic                      lk_done_o,
    output logic                      lk_hit_o,
    output logic [VA_W-1:0]           lk_paddr_o,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [VA_W-PAGE_BITS-1:0] wr_vpn_i,
    input  logic [VA_W-PAGE_BITS-1:0] wr_pfn_i,
    input  logic [ASID_W-1:0]         wr_asid_i,
    input  logic                      wr_global_i,
    input  logic                      flush_i,
    input  logic                      flush_all_i,
    input  logic [ASID_W-1:0]         flush_asid_i,
    output logic                      busy_o,
    output logic                      flush_done_o
);

    localparam int VPN_W = VA_W - PAGE_BITS;
    localparam int IDX_W = $clog2(ENTRIES);

    // Entry storage
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] global_q, global_d;
    logic [VPN_W-1:0]   vpn_q  [ENTRIES];
    logic [VPN_W-1:0]   vpn_d  [ENTRIES];
    logic [VPN_W-1:0]   pfn_q  [ENTRIES];
    logic [VPN_W-1:0]   pfn_d  [ENTRIES];
    logic [ASID_W-1:0]  asid_q [ENTRIES];
    logic [ASID_W-1:0]  asid_d [ENTRIES];

    // Walker, replacement and output registers
    tlb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   flush_idx_q, flush_idx_d;
    logic               flush_all_q, flush_all_d;
    logic [ASID_W-1:0]  flush_asid_q, flush_asid_d;
    logic [IDX_W-1:0]   victim_q, victim_d;
    logic               lk_done_q, lk_done_d;
    logic               lk_hit_q, lk_hit_d;
    logic [VA_W-1:0]    lk_paddr_q, lk_paddr_d;
    logic               flush_done_q, flush_done_d;

    logic [ENTRIES*VPN_W-1:0]  vpn_flat;
    logic [ENTRIES*ASID_W-1:0] asid_flat;
    logic                      accept_ok;
    logic                      lk_fire;
    logic                      wr_fire;
    logic                      lk_hit;
    logic [IDX_W-1:0]          lk_idx;
    logic                      probe_hit;
    logic [IDX_W-1:0]          probe_idx;
    logic                      inv_found;
    logic [IDX_W-1:0]          inv_idx;
    logic [IDX_W-1:0]          wr_idx;

    // A flush request wins over any lookup/refill offered in the same cycle.
    assign accept_ok    = (state_q == ST_IDLE) & ~flush_i;
    assign lk_ready_o   = accept_ok;
    assign wr_ready_o   = accept_ok;
    assign lk_fire      = lk_valid_i & accept_ok;
    assign wr_fire      = wr_valid_i & accept_ok;
    assign busy_o       = (state_q == ST_FLUSH);
    assign lk_done_o    = lk_done_q;
    assign lk_hit_o     = lk_hit_q;
    assign lk_paddr_o   = lk_paddr_q;
    assign flush_done_o = flush_done_q;

    // Flatten the entry fields for the shared matcher.
    always_comb begin
        vpn_flat  = '0;
        asid_flat = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            vpn_flat[i*VPN_W +: VPN_W]    = vpn_q[i];
            asid_flat[i*ASID_W +: ASID_W] = asid_q[i];
        end
    end

    tlb_match #(
        .ENTRIES (ENTRIES),
        .VPN_W   (VPN_W),
        .ASID_W  (ASID_W)
    ) u_lookup_match (
        .ent_valid_i  (valid_q),
        .ent_global_i (global_q),
        .ent_vpn_i    (vpn_flat),
        .ent_asid_i   (asid_flat),
        .key_vpn_i    (lk_vaddr_i[VA_W-1:PAGE_BITS]),
        .key_asid_i   (lk_asid_i),
        .hit_o        (lk_hit),
        .idx_o        (lk_idx)
    );

    // Refill probe: an existing matching entry is overwritten so no duplicates appear.
    tlb_match #(
        .ENTRIES (ENTRIES),
        .VPN_W   (VPN_W),
        .ASID_W  (ASID_W)
    ) u_refill_match (
        .ent_valid_i  (valid_q),
        .ent_global_i (global_q),
        .ent_vpn_i    (vpn_flat),
        .ent_asid_i   (asid_flat),
        .key_vpn_i    (wr_vpn_i),
        .key_asid_i   (wr_asid_i),
        .hit_o        (probe_hit),
        .idx_o        (probe_idx)
    );

    // Lookup result uses pre-write contents; miss reports a zero address.
    always_comb begin
        lk_done_d  = lk_fire;
        lk_hit_d   = lk_fire & lk_hit;
        lk_paddr_d = '0;
        if (lk_fire && lk_hit) begin
            lk_paddr_d = {pfn_q[lk_idx], lk_vaddr_i[PAGE_BITS-1:0]};
        end
    end

    // Refill slot: existing match, else lowest invalid, else round-robin victim.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
        end
        victim_d = victim_q;
        if (probe_hit) begin
            wr_idx = probe_idx;
        end else if (inv_found) begin
            wr_idx = inv_idx;
        end else begin
            wr_idx = victim_q;
            if (wr_fire) begin
                victim_d = victim_q + 1'b1;
            end
        end
    end

    // Next entry contents: install on refill, clear the walked entry during flush.
    always_comb begin
        valid_d  = valid_q;
        global_d = global_q;
        vpn_d    = vpn_q;
        pfn_d    = pfn_q;
        asid_d   = asid_q;
        if (wr_fire) begin
            valid_d[wr_idx]  = 1'b1;
            global_d[wr_idx] = wr_global_i;
            vpn_d[wr_idx]    = wr_vpn_i;
            pfn_d[wr_idx]    = wr_pfn_i;
            asid_d[wr_idx]   = wr_asid_i;
        end
        if (state_q == ST_FLUSH) begin
            if (flush_all_q ||
                ((asid_q[flush_idx_q] == flush_asid_q) && !global_q[flush_idx_q])) begin
                valid_d[flush_idx_q] = 1'b0;
            end
        end
    end

    // Flush walker: one entry per cycle, done pulse once the last index is processed.
    always_comb begin
        state_d      = state_q;
        flush_idx_d  = flush_idx_q;
        flush_all_d  = flush_all_q;
        flush_asid_d = flush_asid_q;
        flush_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d      = ST_FLUSH;
                    flush_idx_d  = '0;
                    flush_all_d  = flush_all_i;
                    flush_asid_d = flush_asid_i;
                end
            end
            ST_FLUSH: begin
                flush_idx_d = flush_idx_q + 1'b1;
                if (flush_idx_q == IDX_W'(ENTRIES - 1)) begin
                    flush_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All state registers; reset clears every valid bit and aborts a running flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            flush_idx_q  <= '0;
            flush_all_q  <= 1'b0;
            flush_asid_q <= '0;
            victim_q     <= '0;
            lk_done_q    <= 1'b0;
            lk_hit_q     <= 1'b0;
            lk_paddr_q   <= '0;
            flush_done_q <= 1'b0;
            valid_q      <= '0;
            global_q     <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                vpn_q[i]  <= '0;
                pfn_q[i]  <= '0;
                asid_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            flush_idx_q  <= flush_idx_d;
            flush_all_q  <= flush_all_d;
            flush_asid_q <= flush_asid_d;
            victim_q     <= victim_d;
            lk_done_q    <= lk_done_d;
            lk_hit_q     <= lk_hit_d;
            lk_paddr_q   <= lk_paddr_d;
            flush_done_q <= flush_done_d;
            valid_q      <= valid_d;
            global_q     <= global_d;
            for (int i = 0; i < ENTRIES; i++) begin
                vpn_q[i]  <= vpn_d[i];
                pfn_q[i]  <= pfn_d[i];
                asid_q[i] <= asid_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tlb_assoc.sv
// Directed and randomized bench for tlb_assoc against a table-level reference model.
// Latency: lookup results checked one cycle after acceptance.
// Backpressure: checks that flush refuses lookups/refills and lasts exactly 16 cycles.
module tb_tlb_assoc;

    logic        clk;
    logic        rst;
    logic        lk_valid_i;
    logic        lk_ready_o;
    logic [31:0] lk_vaddr_i;
    logic [7:0]  lk_asid_i;
    logic        lk_done_o;
    logic        lk_hit_o;
    logic [31:0] lk_paddr_o;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [19:0] wr_vpn_i;
    logic [19:0] wr_pfn_i;
    logic [7:0]  wr_asid_i;
    logic        wr_global_i;
    logic        flush_i;
    logic        flush_all_i;
    logic [7:0]  flush_asid_i;
    logic        busy_o;
    logic        flush_done_o;

    int vectors;
    int miscompares;

    // Reference table: slot order only matters for replacement and multi-hit priority.
    bit         m_valid [16];
    bit         m_glob  [16];
    bit [19:0]  m_vpn   [16];
    bit [19:0]  m_pfn   [16];
    bit [7:0]   m_asid  [16];
    int         m_victim;

    tlb_assoc dut (
        .clk          (clk),
        .rst          (rst),
        .lk_valid_i   (lk_valid_i),
        .lk_ready_o   (lk_ready_o),
        .lk_vaddr_i   (lk_vaddr_i),
        .lk_asid_i    (lk_asid_i),
        .lk_done_o    (lk_done_o),
        .lk_hit_o     (lk_hit_o),
        .lk_paddr_o   (lk_paddr_o),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_vpn_i     (wr_vpn_i),
        .wr_pfn_i     (wr_pfn_i),
        .wr_asid_i    (wr_asid_i),
        .wr_global_i  (wr_global_i),
        .flush_i      (flush_i),
        .flush_all_i  (flush_all_i),
        .flush_asid_i (flush_asid_i),
        .busy_o       (busy_o),
        .flush_done_o (flush_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_victim = 0;
    endtask

    task automatic m_lookup(input bit [19:0] vpn, input bit [7:0] asid,
                            output bit hit, output bit [19:0] pfn);
        hit = 1'b0;
        pfn = '0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && m_valid[i] && m_vpn[i] == vpn && (m_glob[i] || m_asid[i] == asid)) begin
                hit = 1'b1;
                pfn = m_pfn[i];
            end
        end
    endtask

    task automatic m_write(input bit [19:0] vpn, input bit [19:0] pfn,
                           input bit [7:0] asid, input bit g);
        int t;
        t = -1;
        for (int i = 0; i < 16; i++)
            if (t < 0 && m_valid[i] && m_vpn[i] == vpn && (m_glob[i] || m_asid[i] == asid)) t = i;
        for (int i = 0; i < 16; i++)
            if (t < 0 && !m_valid[i]) t = i;
        if (t < 0) begin
            t = m_victim;
            m_victim = (m_victim + 1) % 16;
        end
        m_valid[t] = 1'b1;
        m_vpn[t]   = vpn;
        m_pfn[t]   = pfn;
        m_asid[t]  = asid;
        m_glob[t]  = g;
    endtask

    task automatic m_flush(input bit all, input bit [7:0] asid);
        for (int i = 0; i < 16; i++)
            if (all || (m_asid[i] == asid && !m_glob[i])) m_valid[i] = 1'b0;
    endtask

    // One idle-state cycle with optional lookup and/or refill, checked against the model.
    task automatic step(input bit lv, input logic [31:0] va, input logic [7:0] la,
                        input bit wv, input logic [19:0] vpn, input logic [19:0] pfn,
                        input logic [7:0] wa, input bit wg);
        bit        eh;
        bit [19:0] ep;
        @(negedge clk);
        lk_valid_i  = lv;
        lk_vaddr_i  = va;
        lk_asid_i   = la;
        wr_valid_i  = wv;
        wr_vpn_i    = vpn;
        wr_pfn_i    = pfn;
        wr_asid_i   = wa;
        wr_global_i = wg;
        #1;
        chk("lk_ready_idle", lk_ready_o, 1);
        m_lookup(va[31:12], la, eh, ep);
        @(posedge clk);
        #1;
        if (wv) m_write(vpn, pfn, wa, wg);
        chk("lk_done", lk_done_o, lv);
        if (lv) begin
            chk("lk_hit", lk_hit_o, eh);
            chk("lk_paddr", lk_paddr_o, eh ? {ep, va[11:0]} : 32'h0);
        end
        lk_valid_i = 1'b0;
        wr_valid_i = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] va, input logic [7:0] la);
        step(1'b1, va, la, 1'b0, 20'h0, 20'h0, 8'h0, 1'b0);
    endtask

    task automatic write(input logic [19:0] vpn, input logic [19:0] pfn,
                         input logic [7:0] wa, input bit wg);
        step(1'b0, 32'h0, 8'h0, 1'b1, vpn, pfn, wa, wg);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_clear();
    endtask

    // Flush with a competing lookup/refill; measures busy length and done pulse.
    task automatic run_flush(input bit all, input logic [7:0] fa);
        int busy_cnt;
        int ready_bad;
        bit done_seen;
        bit busy_at_done;
        @(negedge clk);
        flush_i      = 1'b1;
        flush_all_i  = all;
        flush_asid_i = fa;
        lk_valid_i   = 1'b1;
        lk_vaddr_i   = 32'h00400000;
        lk_asid_i    = fa;
        wr_valid_i   = 1'b1;
        wr_vpn_i     = 20'hFFFFF;
        wr_pfn_i     = 20'h12121;
        wr_asid_i    = fa;
        wr_global_i  = 1'b1;
        #1;
        chk("flush_lk_ready", lk_ready_o, 0);
        chk("flush_wr_ready", wr_ready_o, 0);
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        lk_valid_i = 1'b0;
        wr_valid_i = 1'b0;
        chk("flush_lk_refused", lk_done_o, 0);
        busy_cnt     = busy_o ? 1 : 0;
        ready_bad    = 0;
        done_seen    = 1'b0;
        busy_at_done = 1'b0;
        for (int c = 0; c < 64 && !done_seen; c++) begin
            flush_i = (c == 3);
            @(posedge clk);
            #1;
            if (busy_o) busy_cnt++;
            if (busy_o && (lk_ready_o || wr_ready_o)) ready_bad++;
            if (flush_done_o) begin
                done_seen    = 1'b1;
                busy_at_done = busy_o;
            end
        end
        flush_i = 1'b0;
        chk("flush_done_seen", done_seen, 1);
        chk("flush_busy_cycles", busy_cnt, 16);
        chk("flush_busy_at_done", busy_at_done, 0);
        chk("flush_ready_while_busy", ready_bad, 0);
        @(posedge clk);
        #1;
        chk("flush_done_width", flush_done_o, 0);
        m_flush(all, fa);
    endtask

    initial begin
        bit        lv, wv, g;
        logic [19:0] rv, wvp, pf;
        logic [7:0]  a1, a2;

        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        lk_valid_i   = 1'b0;
        lk_vaddr_i   = '0;
        lk_asid_i    = '0;
        wr_valid_i   = 1'b0;
        wr_vpn_i     = '0;
        wr_pfn_i     = '0;
        wr_asid_i    = '0;
        wr_global_i  = 1'b0;
        flush_i      = 1'b0;
        flush_all_i  = 1'b0;
        flush_asid_i = '0;
        m_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lk_done", lk_done_o, 0);
        chk("rst_lk_hit", lk_hit_o, 0);
        chk("rst_lk_paddr", lk_paddr_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_flush_done", flush_done_o, 0);
        chk("rst_lk_ready", lk_ready_o, 1);
        chk("rst_wr_ready", wr_ready_o, 1);
        @(negedge clk);
        rst = 1'b0;

        // Basic translate and ASID qualification
        write(20'h12345, 20'h00ABC, 8'd3, 1'b0);
        lookup(32'h12345678, 8'd3);
        chk("t1_hit_const", lk_hit_o, 1);
        chk("t1_paddr_const", lk_paddr_o, 32'h00ABC678);
        lookup(32'h12345678, 8'd4);
        chk("t1_miss_const", lk_hit_o, 0);
        chk("t1_miss_paddr", lk_paddr_o, 32'h0);

        // Global entry hits under any ASID
        write(20'h00400, 20'h11111, 8'd9, 1'b1);
        lookup(32'h00400ABC, 8'd0);
        lookup(32'h00400001, 8'd7);
        lookup(32'h00400FFF, 8'd255);
        chk("t2_global_255", lk_paddr_o, 32'h11111FFF);

        // Same-cycle lookup and write of the same VPN: lookup sees old contents
        step(1'b1, 32'h55555123, 8'd2, 1'b1, 20'h55555, 20'h66666, 8'd2, 1'b0);
        chk("t5_same_cycle_miss", lk_hit_o, 0);
        lookup(32'h55555123, 8'd2);
        chk("t5_next_hit", lk_paddr_o, 32'h66666123);

        // Replacement: fill, evict round-robin, overwrite in place
        do_reset();
        for (int i = 0; i < 16; i++) write(20'h00100 + 20'(i), 20'h02000 + 20'(i), 8'd1, 1'b0);
        write(20'h00200, 20'h03000, 8'd1, 1'b0);
        write(20'h00201, 20'h03001, 8'd1, 1'b0);
        write(20'h00105, 20'hAAAAA, 8'd1, 1'b0);
        write(20'h00202, 20'h03002, 8'd1, 1'b0);
        lookup(32'h00100000, 8'd1);
        chk("t3_evict0", lk_hit_o, 0);
        lookup(32'h00101000, 8'd1);
        lookup(32'h00102000, 8'd1);
        chk("t3_evict2_after_overwrite", lk_hit_o, 0);
        lookup(32'h00103000, 8'd1);
        lookup(32'h00105234, 8'd1);
        chk("t3_overwrite_pfn", lk_paddr_o, 32'hAAAAA234);
        for (int i = 0; i < 3; i++) lookup({20'h00200 + 20'(i), 12'h010}, 8'd1);

        // Randomized traffic over a small key space (evictions, multi-hits, same-cycle pairs)
        for (int n = 0; n < 300; n++) begin
            lv  = 1'($urandom_range(0, 1));
            wv  = 1'($urandom_range(0, 1));
            rv  = 20'h30000 | 20'($urandom_range(0, 7));
            wvp = 20'h30000 | 20'($urandom_range(0, 7));
            pf  = 20'($urandom);
            a1  = 8'($urandom_range(0, 3));
            a2  = 8'($urandom_range(0, 3));
            g   = ($urandom_range(0, 7) == 0);
            step(lv, {rv, 12'($urandom)}, a1, wv, wvp, pf, a2, g);
        end

        // ASID-selective flush over a mix of asid 3 / asid 5 / global entries
        do_reset();
        for (int i = 0; i < 12; i++)
            write(20'h00200 + 20'(i), 20'h04000 + 20'(i),
                  (i % 3 == 1) ? 8'd5 : 8'd3, (i % 3 == 2));
        run_flush(1'b0, 8'd3);
        for (int i = 0; i < 12; i++) lookup({20'h00200 + 20'(i), 12'h0AB}, 8'd3);
        for (int i = 0; i < 12; i++) lookup({20'h00200 + 20'(i), 12'h0CD}, 8'd5);
        lookup(32'h00200000, 8'd3);
        chk("t4_asid3_cleared", lk_hit_o, 0);
        lookup(32'h00202000, 8'd3);
        chk("t4_global_kept", lk_hit_o, 1);

        // Full flush
        run_flush(1'b1, 8'd0);
        for (int i = 0; i < 12; i++) lookup({20'h00200 + 20'(i), 12'h0EF}, 8'd5);

        // Reset in the middle of a flush aborts it and clears the table
        for (int i = 0; i < 4; i++) write(20'h00700 + 20'(i), 20'h05000 + 20'(i), 8'd6, 1'b1);
        @(negedge clk);
        flush_i      = 1'b1;
        flush_all_i  = 1'b0;
        flush_asid_i = 8'd1;
        @(negedge clk);
        flush_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("t6_busy_before_rst", busy_o, 1);
        rst = 1'b1;
        #1;
        chk("t6_busy_after_rst", busy_o, 0);
        chk("t6_done_after_rst", flush_done_o, 0);
        @(negedge clk);
        rst = 1'b0;
        m_clear();
        for (int i = 0; i < 4; i++) lookup({20'h00700 + 20'(i), 12'h111}, 8'd6);
        chk("t6_miss_after_rst", lk_hit_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
